// File: rtl/load_store_unit.sv
// +----------------------------------------------------------------------------+
// | load_store_unit : CPU load/store engine with sub-word extract and RMW.      |
// | Optional feature macro: LSU_SUBWORD_EN (byte/halfword access).   Rev 1.0   |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module load_store_unit #(
  parameter logic [31:0] RESET_RDATA = 32'h0
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        unsigned_q, unsigned_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] mem_wd_q, mem_wd_d;

  logic        misaligned;
  logic [31:0] shifted;
  logic [31:0] load_ext;

`ifdef LSU_SUBWORD_EN
  assign misaligned = (req_size == 2'b11) ||
                      ((req_size == 2'b01) && req_addr[0]) ||
                      ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign misaligned = (req_size != 2'b10) || (req_addr[1:0] != 2'b00);
`endif

  // Aligned halfwords sit at shift 0 or 16, so one shifter serves both sizes.
  assign shifted = mem_rd >> {addr_q[1:0], 3'b000};

  always_comb begin
    load_ext = mem_rd;
    case (size_q)
      2'b00:   load_ext = {{24{shifted[7] & ~unsigned_q}}, shifted[7:0]};
      2'b01:   load_ext = {{16{shifted[15] & ~unsigned_q}}, shifted[15:0]};
      default: load_ext = mem_rd;
    endcase
  end

`ifdef LSU_SUBWORD_EN
  logic [31:0] merged;

  // Store data is held right-aligned in mem_wd_q until the old word arrives.
  always_comb begin
    merged = mem_rd;
    case (size_q)
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8]  = mem_wd_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16]  = mem_wd_q[15:0];
      default: merged = mem_wd_q;
    endcase
  end
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    mem_wd_d   = mem_wd_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d     = req_addr;
          we_d       = req_we;
          size_d     = req_size;
          unsigned_d = req_unsigned;
          err_d      = misaligned;
          if (misaligned) begin
            state_d = RESP;
          end else begin
            if (req_we) begin
              mem_wd_d = req_wdata;
            end
            if (req_we && (req_size == 2'b10)) begin
              state_d = WRITE;
            end else begin
              state_d = READ;
            end
          end
        end
      end
      READ: begin
`ifdef LSU_SUBWORD_EN
        if (we_q) begin
          mem_wd_d = merged;
          state_d  = WRITE;
        end else begin
          rdata_d = load_ext;
          state_d = RESP;
        end
`else
        rdata_d = we_q ? 32'h0 : load_ext;
        state_d = RESP;
`endif
      end
      WRITE: begin
        rdata_d = 32'h0;
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= 32'h0;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= RESET_RDATA;
      mem_wd_q   <= 32'h0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      mem_wd_q   <= mem_wd_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_err   = (state_q == RESP) && err_q;
  assign resp_rdata = rdata_q;
  assign mem_we     = (state_q == WRITE);
  assign mem_a      = {addr_q[31:2], 2'b00};
  assign mem_wd     = mem_wd_q;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed scenarios plus randomized traffic
// checked against a word-array reference model.
`timescale 1ns/1ps
`default_nettype none

module tb_load_store_unit;

  localparam logic [31:0] RST_RD = 32'hCAFEF00D;
`ifdef LSU_SUBWORD_EN
  localparam bit SUBWORD = 1'b1;
`else
  localparam bit SUBWORD = 1'b0;
`endif

  logic        CLK;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  int checks = 0;
  int errors = 0;

  load_store_unit #(.RESET_RDATA(RST_RD)) dut (
    .CLK(CLK), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd),
    .mem_rd(mem_rd)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Data memory (1 KiB) and the bench's independent reference copy.
  logic [31:0] mem [0:255];
  logic        mem_clr;
  logic [31:0] ref_mem [0:255];
  logic [31:0] ref_rdata;

  assign mem_rd = mem[mem_a[9:2]];
  always @(posedge CLK) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    end else if (mem_we) begin
      mem[mem_a[9:2]] <= mem_wd;
    end
  end

  function automatic void predict(input bit we, input logic [1:0] size, input bit uns,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [31:0] word, input logic [31:0] prev,
                                  output bit err, output logic [31:0] rd,
                                  output logic [31:0] nw, output int lat, output int nwe);
    bit legal;
    int nbits, sh;
    logic [63:0] mask, v;
    if (SUBWORD) legal = (size == 0) || (size == 1 && addr % 2 == 0) || (size == 2 && addr % 4 == 0);
    else         legal = (size == 2) && (addr % 4 == 0);
    nw = word;
    if (!legal) begin
      err = 1; rd = prev; lat = 1; nwe = 0;
      return;
    end
    err   = 0;
    nbits = 8 * (1 << size);
    sh    = 8 * int'(addr % 4);
    mask  = (64'd1 << nbits) - 64'd1;
    if (we) begin
      v   = (64'(word) & ~(mask << sh)) | ((64'(wdata) & mask) << sh);
      nw  = v[31:0];
      rd  = 32'h0;
      lat = (size == 2) ? 2 : 3;
      nwe = 1;
    end else begin
      v = (64'(word) >> sh) & mask;
      if (!uns && v[nbits-1]) v = v | ~mask;
      rd  = v[31:0];
      lat = 2;
      nwe = 0;
    end
  endfunction

  // Issues one request (caller sits at a negedge) and records what the DUT did.
  task automatic run_op(input bit we, input logic [1:0] size, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input bit noise,
                        output logic [31:0] rd, output bit err, output int lat, output int wec,
                        output logic [31:0] wa, output logic [31:0] wd, output int waits,
                        output bit tmo);
    bit done;
    done = 0; rd = '0; err = 0; lat = 0; wec = 0; wa = '0; wd = '0; waits = 0;
    req_valid = 1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    while (!req_ready && waits < 4) begin
      @(negedge CLK);
      waits++;
    end
    @(posedge CLK);
    while (!done && lat < 8) begin
      @(negedge CLK);
      lat++;
      req_valid = noise;
      if (noise) begin
        req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
      end
      if (mem_we) begin
        wec++; wa = mem_a; wd = mem_wd;
      end
      if (resp_valid) begin
        rd = resp_rdata; err = resp_err; done = 1;
      end
    end
    req_valid = 0;
    tmo = !done;
  endtask

  logic [31:0] rd, wa, wd;
  bit          err, tmo;
  int          lat, wec, waits;

  task automatic test_reset();
    reset = 1; mem_clr = 1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", resp_valid); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", resp_err); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", mem_we); end
    checks++; if (mem_wd !== 32'h0) begin errors++; $display("FAIL rst_wd: got %h want 0", mem_wd); end
    checks++; if (mem_a !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", mem_a); end
    checks++; if (resp_rdata !== RST_RD) begin errors++; $display("FAIL rst_rdata: got %h want %h", resp_rdata, RST_RD); end
    reset = 0; mem_clr = 0;
    ref_rdata = RST_RD;
  endtask

  task automatic test_word_store_load();
    run_op(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, rd, err, lat, wec, wa, wd, waits, tmo);
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL wst_timeout: got %b want 0", tmo); end
    checks++; if (wec !== 1) begin errors++; $display("FAIL wst_we_pulses: got %0d want 1", wec); end
    checks++; if (wa !== 32'h10) begin errors++; $display("FAIL wst_addr: got %h want 00000010", wa); end
    checks++; if (wd !== 32'hDEADBEEF) begin errors++; $display("FAIL wst_data: got %h want deadbeef", wd); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL wst_rdata: got %h want 0", rd); end
    run_op(0, 2'b10, 0, 32'h10, 32'h0, 0, rd, err, lat, wec, wa, wd, waits, tmo);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL wld_rdata: got %h want deadbeef", rd); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL wld_latency: got %0d want 2", lat); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL wld_err: got %b want 0", err); end
    checks++; if (wec !== 0) begin errors++; $display("FAIL wld_we_pulses: got %0d want 0", wec); end
  endtask

  task automatic test_subword_load();
    logic [31:0] exp_rd [3];
    logic [1:0]  sz [3];
    logic [31:0] ad [3];
    bit          un [3];
    exp_rd[0] = SUBWORD ? 32'h00000011 : 32'h0; sz[0] = 2'b00; ad[0] = 32'h83; un[0] = 0;
    exp_rd[1] = SUBWORD ? 32'hFFFFF00D : 32'h0; sz[1] = 2'b01; ad[1] = 32'h82; un[1] = 0;
    exp_rd[2] = SUBWORD ? 32'h0000F00D : 32'h0; sz[2] = 2'b01; ad[2] = 32'h82; un[2] = 1;
    for (int i = 0; i < 3; i++) begin
      run_op(1, 2'b10, 0, 32'h80, (i == 0) ? 32'h11223344 : 32'hF00D0000, 0,
             rd, err, lat, wec, wa, wd, waits, tmo);
      run_op(0, sz[i], un[i], ad[i], 32'h0, 0, rd, err, lat, wec, wa, wd, waits, tmo);
      checks++; if (rd !== exp_rd[i]) begin errors++; $display("FAIL sub_load%0d_rdata: got %h want %h", i, rd, exp_rd[i]); end
      checks++; if (err !== !SUBWORD) begin errors++; $display("FAIL sub_load%0d_err: got %b want %b", i, err, !SUBWORD); end
      checks++; if (lat !== (SUBWORD ? 2 : 1)) begin errors++; $display("FAIL sub_load%0d_latency: got %0d want %0d", i, lat, SUBWORD ? 2 : 1); end
    end
  endtask

  task automatic test_subword_store();
    logic [31:0] exp_word;
    exp_word = SUBWORD ? 32'hAABB5ADD : 32'hAABBCCDD;
    run_op(1, 2'b10, 0, 32'h20, 32'hAABBCCDD, 0, rd, err, lat, wec, wa, wd, waits, tmo);
    run_op(1, 2'b00, 0, 32'h21, 32'h1234565A, 0, rd, err, lat, wec, wa, wd, waits, tmo);
    checks++; if (lat !== (SUBWORD ? 3 : 1)) begin errors++; $display("FAIL sb_latency: got %0d want %0d", lat, SUBWORD ? 3 : 1); end
    checks++; if (err !== !SUBWORD) begin errors++; $display("FAIL sb_err: got %b want %b", err, !SUBWORD); end
    checks++; if (wec !== (SUBWORD ? 1 : 0)) begin errors++; $display("FAIL sb_we_pulses: got %0d want %0d", wec, SUBWORD ? 1 : 0); end
    checks++; if (mem[8] !== exp_word) begin errors++; $display("FAIL sb_word: got %h want %h", mem[8], exp_word); end
    if (SUBWORD) begin
      checks++; if (wa !== 32'h20) begin errors++; $display("FAIL sb_addr: got %h want 00000020", wa); end
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL sb_rdata: got %h want 0", rd); end
    end
  endtask

  task automatic test_misaligned();
    logic        mwe [3];
    logic [1:0]  msz [3];
    logic [31:0] mad [3];
    mwe[0] = 0; msz[0] = 2'b10; mad[0] = 32'h22;
    mwe[1] = 1; msz[1] = 2'b01; mad[1] = 32'h13;
    mwe[2] = 0; msz[2] = 2'b11; mad[2] = 32'h40;
    run_op(0, 2'b10, 0, 32'h10, 32'h0, 0, rd, err, lat, wec, wa, wd, waits, tmo);
    for (int i = 0; i < 3; i++) begin
      run_op(mwe[i], msz[i], 0, mad[i], 32'h55AA55AA, 0, rd, err, lat, wec, wa, wd, waits, tmo);
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL mis%0d_err: got %b want 1", i, err); end
      checks++; if (lat !== 1) begin errors++; $display("FAIL mis%0d_latency: got %0d want 1", i, lat); end
      checks++; if (wec !== 0) begin errors++; $display("FAIL mis%0d_we_pulses: got %0d want 0", i, wec); end
      checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL mis%0d_rdata: got %h want deadbeef", i, rd); end
    end
    checks++; if (mem[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL mis_mem: got %h want deadbeef", mem[4]); end
  endtask

  task automatic test_back_to_back();
    int w1;
    run_op(1, 2'b10, 0, 32'h30, 32'h13579BDF, 1, rd, err, lat, wec, wa, wd, waits, tmo);
    w1 = wec;
    run_op(0, 2'b10, 0, 32'h30, 32'h0, 1, rd, err, lat, wec, wa, wd, waits, tmo);
    checks++; if (w1 !== 1) begin errors++; $display("FAIL b2b_we_pulses: got %0d want 1", w1); end
    checks++; if (waits !== 1) begin errors++; $display("FAIL b2b_accept_delay: got %0d want 1", waits); end
    checks++; if (rd !== 32'h13579BDF) begin errors++; $display("FAIL b2b_rdata: got %h want 13579bdf", rd); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL b2b_latency: got %0d want 2", lat); end
  endtask

  task automatic test_reset_mid_op();
    int we_seen = 0;
    int rv_seen = 0;
    logic [31:0] w8;
    w8 = mem[8];
    @(negedge CLK);
    req_valid = 1; req_unsigned = 0; req_wdata = 32'h000000EE;
    if (SUBWORD) begin req_we = 1; req_size = 2'b00; req_addr = 32'h21; end
    else         begin req_we = 0; req_size = 2'b10; req_addr = 32'h20; end
    @(posedge CLK);
    @(negedge CLK);
    req_valid = 0; reset = 1;
    if (mem_we) we_seen++;
    if (resp_valid) rv_seen++;
    @(negedge CLK);
    reset = 0;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %b want 1", req_ready); end
    checks++; if (resp_rdata !== RST_RD) begin errors++; $display("FAIL rmid_rdata: got %h want %h", resp_rdata, RST_RD); end
    repeat (4) begin
      if (mem_we) we_seen++;
      if (resp_valid) rv_seen++;
      @(negedge CLK);
    end
    checks++; if (we_seen !== 0) begin errors++; $display("FAIL rmid_we: got %0d pulses want 0", we_seen); end
    checks++; if (rv_seen !== 0) begin errors++; $display("FAIL rmid_resp: got %0d pulses want 0", rv_seen); end
    checks++; if (mem[8] !== w8) begin errors++; $display("FAIL rmid_mem: got %h want %h", mem[8], w8); end
  endtask

  task automatic test_random();
    bit          we, uns, noise, e_err;
    logic [1:0]  size;
    logic [31:0] addr, wdata, e_rd, e_nw;
    int          e_lat, e_we, idx;
    @(negedge CLK); reset = 1;
    @(negedge CLK); reset = 0;
    ref_rdata = RST_RD;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
    for (int n = 0; n < 60; n++) begin
      we = 1'($urandom); size = 2'($urandom); uns = 1'($urandom); noise = 1'($urandom);
      addr = 32'h200 + $urandom_range(0, 511); wdata = $urandom;
      idx = int'(addr[9:2]);
      predict(we, size, uns, addr, wdata, ref_mem[idx], ref_rdata, e_err, e_rd, e_nw, e_lat, e_we);
      run_op(we, size, uns, addr, wdata, noise, rd, err, lat, wec, wa, wd, waits, tmo);
      checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL rnd%0d_timeout: got %b want 0", n, tmo); end
      checks++; if (err !== e_err) begin errors++; $display("FAIL rnd%0d_err: got %b want %b", n, err, e_err); end
      checks++; if (rd !== e_rd) begin errors++; $display("FAIL rnd%0d_rdata: got %h want %h", n, rd, e_rd); end
      checks++; if (lat !== e_lat) begin errors++; $display("FAIL rnd%0d_latency: got %0d want %0d", n, lat, e_lat); end
      checks++; if (wec !== e_we) begin errors++; $display("FAIL rnd%0d_we_pulses: got %0d want %0d", n, wec, e_we); end
      checks++; if (mem[idx] !== e_nw) begin errors++; $display("FAIL rnd%0d_mem: got %h want %h", n, mem[idx], e_nw); end
      if (e_we == 1) begin
        checks++; if (wa !== {addr[31:2], 2'b00}) begin errors++; $display("FAIL rnd%0d_addr: got %h want %h", n, wa, {addr[31:2], 2'b00}); end
      end
      ref_mem[idx] = e_nw;
      ref_rdata = e_rd;
    end
  endtask

  initial begin
    req_valid = 0; req_we = 0; req_size = 2'b10; req_unsigned = 0;
    req_addr = 32'h0; req_wdata = 32'h0;
    test_reset();
    @(negedge CLK);
    test_word_store_load();
    test_subword_load();
    test_subword_store();
    test_misaligned();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: RESET_RDATA, default 32'h0, value of resp_rdata after reset.
REQ-002 CLK  input  1  rising-edge clock; sole clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  CPU request strobe.
REQ-005 req_ready  output  1  high only in IDLE; a request is accepted when req_valid && req_ready at a CLK edge.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-008 req_unsigned  input  1  load zero-extends when 1 and sign-extends when 0.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-aligned.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  32  extended load data, valid with resp_valid.
REQ-013 resp_err  output  1  misaligned/unsupported request, valid with resp_valid.
REQ-014 mem_we  output  1  data-memory write enable.
REQ-015 mem_a  output  32  data-memory byte address.
REQ-016 mem_wd  output  32  data-memory write word.
REQ-017 mem_rd  input  32  data-memory read word, combinational from mem_a.

Function
REQ-018 The FSM SHALL have states IDLE, READ, WRITE and RESP; all request fields are latched on acceptance.
REQ-019 mem_a SHALL equal {latched_addr[31:2],2'b00} in all states, so memory never sees a misaligned address.
REQ-020 Misaligned means halfword with addr[0]=1, word with addr[1:0]!=0, or size 11.
REQ-021 Misaligned requests SHALL go IDLE->RESP with resp_err=1 and resp_rdata unchanged, and mem_we SHALL never be asserted.
REQ-022 Load: IDLE->READ->RESP; in READ the unit SHALL capture mem_rd, select the byte/halfword by addr[1:0], and extend it; resp_valid occurs 2 cycles after acceptance.
REQ-023 Word store: IDLE->WRITE->RESP; in WRITE mem_we=1 and mem_wd=wdata.
REQ-024 Sub-word store: IDLE->READ->WRITE->RESP (read-modify-write); only the addressed byte lanes of the captured word are replaced; resp_valid occurs 3 cycles after acceptance.
REQ-025 mem_we SHALL be high for exactly one cycle per store and only in WRITE.
REQ-026 RESP SHALL last one cycle, always return to IDLE, and carry resp_rdata=0 for stores.
REQ-027 req_valid outside IDLE SHALL be ignored; a back-to-back request is accepted in the cycle after RESP.

Reset
REQ-028 While reset is high at a CLK edge, the state SHALL become IDLE, with req_ready=1, resp_valid=0, resp_err=0, mem_we=0, mem_wd=0, resp_rdata=RESET_RDATA, and the latched address=0.
REQ-029 Reset mid-operation SHALL abort the operation with no mem_we pulse and no resp_valid.

Configuration
REQ-030 Macro LSU_SUBWORD_EN defined: byte/halfword loads and stores behave as REQ-022/REQ-024.
REQ-031 LSU_SUBWORD_EN undefined: only req_size=10 is legal; any other size SHALL complete via IDLE->RESP with resp_err=1, and READ->WRITE sequencing is absent.

Verification
REQ-032 Word store addr 0x10 data 0xDEADBEEF, then word load 0x10 -> mem_we pulse with mem_a=0x10; load resp_rdata=0xDEADBEEF two cycles after acceptance, resp_err=0.
REQ-033 Memory word 0x80 = 0x11223344; signed byte load at 0x83 -> 0x00000011; halfword load signed at 0x82 with word 0xF00D0000 -> 0xFFFFF00D; unsigned -> 0x0000F00D.
REQ-034 Memory word 0x20 = 0xAABBCCDD; byte store 0x5A at 0x21 -> written word 0xAABB5ADD, resp_valid 3 cycles after acceptance.
REQ-035 Word load at 0x22 and halfword store at 0x13 -> resp_err=1 one cycle after acceptance; mem_we never high.
REQ-036 Assert reset during READ of a sub-word store -> no mem_we, no resp_valid, req_ready=1 next cycle.
REQ-037 LSU_SUBWORD_EN undefined, byte load at 0x04 -> resp_err=1 with no READ cycle.
